// File: rtl/debounce_pkg.sv
// Shared helpers for the debounced input bank.
package debounce_pkg;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer chain, reload-timer debouncer and
// registered edge pulses. o_change_c flags the edge that updates the level.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGE_COUNT = 2,
    parameter int unsigned TIMER_WIDTH      = 4,
    parameter int unsigned TIMER_INIT       = 15,
    parameter logic        RESET_VALUE      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_data,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_change_c
);

    localparam int unsigned SW = SYNC_STAGE_COUNT;

    logic [SW-1:0]          r_sync;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sample;
    logic                   w_differ;
    logic                   w_expired;

    assign w_sample  = r_sync[SW-1];
    assign w_differ  = (w_sample != r_level);
    assign w_expired = (r_timer == '0);

    // Shift toward the MSB; the cast drops the oldest stage (works for SW == 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SW{RESET_VALUE}};
        end else begin
            r_sync <= SW'({r_sync, i_data});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= TIMER_WIDTH'(TIMER_INIT);
            r_level <= RESET_VALUE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_differ & w_expired & w_sample;
            r_fall <= w_differ & w_expired & ~w_sample;
            if (!w_differ || w_expired) begin
                r_timer <= TIMER_WIDTH'(TIMER_INIT);
            end else begin
                r_timer <= r_timer - TIMER_WIDTH'(1);
            end
            if (w_differ && w_expired) begin
                r_level <= w_sample;
            end
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_change_c = w_differ & w_expired;

endmodule

// File: rtl/debounced_input_bank.sv
// Multi-channel input conditioner with a lowest-index-first event queue,
// valid/ack handshake and sticky per-channel overrun flags.
module debounced_input_bank
    import debounce_pkg::*;
#(
    parameter int unsigned                     CHANNEL_COUNT    = 8,
    parameter int unsigned                     SYNC_STAGE_COUNT = 2,
    parameter int unsigned                     TIMER_WIDTH      = 4,
    parameter int unsigned                     TIMER_INIT       = 15,
    parameter logic [CHANNEL_COUNT-1:0]        RESET_VALUE      = '0,
    localparam int unsigned                    CH_W             = index_width(CHANNEL_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNEL_COUNT-1:0] dataIn,
    output logic [CHANNEL_COUNT-1:0] dataOut,
    output logic [CHANNEL_COUNT-1:0] risingEdge,
    output logic [CHANNEL_COUNT-1:0] fallingEdge,
    output logic                     eventValid,
    output logic [CH_W-1:0]          eventChannel,
    output logic                     eventLevel,
    output logic                     eventOverrun,
    input  logic                     eventAck
);

    logic [CHANNEL_COUNT-1:0] w_change;
    logic [CHANNEL_COUNT-1:0] w_ack_onehot;
    logic [CHANNEL_COUNT-1:0] r_pending;
    logic [CHANNEL_COUNT-1:0] r_overrun;
    logic [CH_W-1:0]          w_sel;
    logic                     w_any;

    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGE_COUNT (SYNC_STAGE_COUNT),
            .TIMER_WIDTH      (TIMER_WIDTH),
            .TIMER_INIT       (TIMER_INIT),
            .RESET_VALUE      (RESET_VALUE[g])
        ) u_chan (
            .clk        (clock),
            .rst        (reset),
            .i_data     (dataIn[g]),
            .o_level    (dataOut[g]),
            .o_rise     (risingEdge[g]),
            .o_fall     (fallingEdge[g]),
            .o_change_c (w_change[g])
        );
    end

    // Priority encoder: scanning downward leaves the lowest pending index.
    always_comb begin
        w_any = |r_pending;
        w_sel = '0;
        for (int i = CHANNEL_COUNT - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = CH_W'(i);
            end
        end
    end

    assign w_ack_onehot = (eventAck && w_any) ? (CHANNEL_COUNT'(1) << w_sel) : '0;

    // A change arriving with the ack re-queues the channel with a clean overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_change | (r_pending & ~w_ack_onehot);
            r_overrun <= ~w_ack_onehot & (r_overrun | (w_change & r_pending));
        end
    end

    assign eventValid   = w_any;
    assign eventChannel = w_sel;
    assign eventLevel   = dataOut[w_sel];
    assign eventOverrun = r_overrun[w_sel];

endmodule

// File: tb/tb_debounced_input_bank.sv
// Randomized and directed bench for debounced_input_bank against a
// run-length / event-queue reference model.
module tb_debounced_input_bank;

    localparam int unsigned N  = 8;
    localparam int unsigned S  = 2;
    localparam int unsigned TW = 4;
    localparam int unsigned TI = 15;
    localparam logic [N-1:0] RV = 8'hA5;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] dataIn;
    logic [N-1:0] dataOut;
    logic [N-1:0] risingEdge;
    logic [N-1:0] fallingEdge;
    logic         eventValid;
    logic [2:0]   eventChannel;
    logic         eventLevel;
    logic         eventOverrun;
    logic         eventAck;

    debounced_input_bank #(
        .CHANNEL_COUNT    (N),
        .SYNC_STAGE_COUNT (S),
        .TIMER_WIDTH      (TW),
        .TIMER_INIT       (TI),
        .RESET_VALUE      (RV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .risingEdge   (risingEdge),
        .fallingEdge  (fallingEdge),
        .eventValid   (eventValid),
        .eventChannel (eventChannel),
        .eventLevel   (eventLevel),
        .eventOverrun (eventOverrun),
        .eventAck     (eventAck)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: level accepted after TI+1 consecutive differing samples.
    logic [N-1:0] m_out, m_rise, m_fall, m_pend, m_ovr;
    logic [N-1:0] m_pipe[$];
    int           m_run[N];
    logic [N-1:0] cur;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest_idx(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_out  = RV;
        m_rise = '0;
        m_fall = '0;
        m_pend = '0;
        m_ovr  = '0;
        m_pipe = {};
        repeat (S) m_pipe.push_back(RV);
        for (int i = 0; i < int'(N); i++) m_run[i] = 0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        logic [N-1:0] sample;
        logic [N-1:0] chg;
        logic         valid;
        int           ch;
        sample = m_pipe.pop_front();
        m_pipe.push_back(dataIn);
        valid = |m_pend;
        ch    = lowest_idx(m_pend);
        chg   = '0;
        for (int i = 0; i < int'(N); i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (sample[i] == m_out[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == int'(TI) + 1) begin
                    chg[i]    = 1'b1;
                    m_out[i]  = sample[i];
                    m_rise[i] = sample[i];
                    m_fall[i] = ~sample[i];
                    m_run[i]  = 0;
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (eventAck && valid && ch == i) begin
                m_pend[i] = chg[i];
                m_ovr[i]  = 1'b0;
            end else if (chg[i]) begin
                if (m_pend[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        int ch;
        ch = lowest_idx(m_pend);
        check_eq("dataOut", 32'(dataOut), 32'(m_out));
        check_eq("risingEdge", 32'(risingEdge), 32'(m_rise));
        check_eq("fallingEdge", 32'(fallingEdge), 32'(m_fall));
        check_eq("eventValid", 32'(eventValid), 32'(|m_pend));
        check_eq("eventChannel", 32'(eventChannel), 32'(ch));
        check_eq("eventLevel", 32'(eventLevel), 32'(m_out[ch]));
        check_eq("eventOverrun", 32'(eventOverrun), 32'(m_ovr[ch]));
    endtask

    // One clock: apply inputs, step the model, compare 1 time unit after the edge.
    task automatic cycle(input logic [N-1:0] din, input logic ack);
        dataIn   = din;
        eventAck = ack;
        model_step();
        @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        check_eq("rst_dataOut", 32'(dataOut), 32'(RV));
        check_eq("rst_rise", 32'(risingEdge), 32'd0);
        check_eq("rst_fall", 32'(fallingEdge), 32'd0);
        check_eq("rst_valid", 32'(eventValid), 32'd0);
        check_eq("rst_channel", 32'(eventChannel), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("release_valid", 32'(eventValid), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * int'(N); k++) begin
            if (!eventValid) break;
            cycle(cur, 1'b1);
        end
        check_eq("drained", 32'(eventValid), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(cur, 1'b0);
    endtask

    initial begin
        int lat;
        int rises;
        int falls;
        reset    = 1'b1;
        eventAck = 1'b0;
        cur      = RV;
        dataIn   = RV;
        @(negedge clock);
        apply_reset();
        idle(5);

        // Settle everything low and clear the resulting events.
        cur = '0;
        idle(22);
        drain();

        // Channel 3 step: rise visible on the 18th edge after the input change.
        cur[3] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            cycle(cur, 1'b0);
            if (risingEdge[3] && lat < 0) lat = k;
        end
        check_eq("ch3_latency", 32'(lat), 32'd18);
        check_eq("ch3_event_channel", 32'(eventChannel), 32'd3);
        check_eq("ch3_event_level", 32'(eventLevel), 32'd1);
        drain();

        // Channel 0: 15-cycle glitch is filtered, 16-cycle pulse passes.
        for (int len = 15; len <= 16; len++) begin
            rises = 0;
            falls = 0;
            for (int k = 0; k < len + 40; k++) begin
                cur[0] = (k < len);
                cycle(cur, 1'b0);
                if (risingEdge[0]) rises++;
                if (fallingEdge[0]) falls++;
            end
            check_eq($sformatf("ch0_pulse%0d_rises", len), 32'(rises), (len == 16) ? 32'd1 : 32'd0);
            check_eq($sformatf("ch0_pulse%0d_falls", len), 32'(falls), (len == 16) ? 32'd1 : 32'd0);
            drain();
        end

        // Channel 1 bounce: toggle every 5 cycles, then hold high.
        rises = 0;
        lat   = -1;
        for (int k = 0; k < 80; k++) begin
            cur[1] = (k >= 40) ? 1'b1 : ((k / 5) % 2 == 0);
            cycle(cur, 1'b0);
            if (risingEdge[1]) begin
                rises++;
                if (lat < 0) lat = k - 39;
            end
        end
        check_eq("ch1_bounce_rises", 32'(rises), 32'd1);
        check_eq("ch1_bounce_latency", 32'(lat), 32'd18);
        drain();

        // Channels 2 and 5 together: lowest index first, then the other.
        cur[2] = 1'b1;
        cur[5] = 1'b1;
        idle(20);
        check_eq("dual_first", 32'(eventChannel), 32'd2);
        cycle(cur, 1'b1);
        check_eq("dual_second", 32'(eventChannel), 32'd5);
        check_eq("dual_second_valid", 32'(eventValid), 32'd1);
        cycle(cur, 1'b1);
        check_eq("dual_empty", 32'(eventValid), 32'd0);
        cycle(cur, 1'b1);

        // Channel 4 changes twice without ack: overrun, latest level shown.
        cur[4] = 1'b1;
        idle(20);
        cur[4] = 1'b0;
        idle(20);
        check_eq("ovr_channel", 32'(eventChannel), 32'd4);
        check_eq("ovr_flag", 32'(eventOverrun), 32'd1);
        check_eq("ovr_level", 32'(eventLevel), 32'd0);
        cycle(cur, 1'b1);
        check_eq("ovr_cleared_valid", 32'(eventValid), 32'd0);
        check_eq("ovr_cleared_flag", 32'(dut.r_overrun[4]), 32'd0);

        // Reset in the middle of a debounce discards the partial count.
        cur[6] = ~cur[6];
        idle(10);
        apply_reset();
        cur = RV;
        idle(30);

        // Random slow-changing inputs with sparse acks.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 19) == 0) cur[i] = ~cur[i];
            end
            cycle(cur, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
